// File: rtl/orb_frame_packer_if.sv
// -----------------------------------------------------------------------------
// orb_frame_packer_if
// Bus between the byte source, the orbital frame packer and the frame RAM
// write port.
//
// Parameters must match the orb_frame_packer instance that uses the bus.
//   DATA_W  : sample width
//   WORD_W  : RAM word width
//   ADDR_W  : RAM address width
//
// Signals
//   iData     source -> packer   sample, stable while strob is high
//   strob     source -> packer   sample strobe (asynchronous level)
//   SW        source -> packer   bank switch (asynchronous level)
//   orbWord   packer -> RAM      {mark, sample, zero pad}
//   WE        packer -> RAM      write enable
//   WrAddr    packer -> RAM      write address
//   packDone  packer -> system   one-clock pulse, packet finished
//   frameDone packer -> system   one-clock pulse, frame finished
//   test      packer -> system   one-clock pulse, bank-switch resync
//
// Modports: master = source/RAM side, slave = packer side.
// -----------------------------------------------------------------------------
interface orb_frame_packer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORD_W = 12,
  parameter int unsigned ADDR_W = 11
);
  logic [DATA_W-1:0] iData;
  logic              strob;
  logic              SW;
  logic [WORD_W-1:0] orbWord;
  logic              WE;
  logic [ADDR_W-1:0] WrAddr;
  logic              packDone;
  logic              frameDone;
  logic              test;

  modport master (
    output iData, strob, SW,
    input  orbWord, WE, WrAddr, packDone, frameDone, test
  );

  modport slave (
    input  iData, strob, SW,
    output orbWord, WE, WrAddr, packDone, frameDone, test
  );
endinterface

// File: rtl/orb_frame_packer.sv
// -----------------------------------------------------------------------------
// orb_frame_packer
// Packs strobed byte samples into fixed-width telemetry words for the orbital
// frame RAM. Each packet has SLOTS_PER_PACK strobe slots; only the first
// WORDS_PER_PACK are written, the rest are consumed as gaps. The very first
// word of a frame carries the mark bit. A change on the bank-switch input
// restarts the frame.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : orb_frame_packer_if.slave (iData/strob/SW in, RAM write and
//          completion pulses out)
//
// WORD_W must equal 1 + DATA_W + PAD_LSB.
// -----------------------------------------------------------------------------
module orb_frame_packer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned PAD_LSB        = 3,
  parameter int unsigned WORD_W         = 12,
  parameter int unsigned WORDS_PER_PACK = 16,
  parameter int unsigned SLOTS_PER_PACK = 20,
  parameter int unsigned PACKS          = 64,
  parameter int unsigned WORD_STRIDE    = 2,
  parameter int unsigned PACK_STRIDE    = 32,
  parameter int unsigned ADDR_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  orb_frame_packer_if.slave bus
);

  localparam int unsigned SLOT_W = (SLOTS_PER_PACK > 1) ? $clog2(SLOTS_PER_PACK) : 1;
  localparam int unsigned PACK_W = (PACKS > 1) ? $clog2(PACKS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Synchroniser stages and previous-bank history
  logic str_meta_q;
  logic str_sync_q;
  logic sw_meta_q;
  logic sw_sync_q;
  logic old_sw_q;

  // FSM state, counters and registered outputs
  state_t            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [PACK_W-1:0] pack_q;
  logic [WORD_W-1:0] word_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pack_done_q;
  logic              frame_done_q;
  logic              test_q;

  // Combinational helpers for the slot being accepted
  logic              resync_s;
  logic              mark_s;
  logic              store_s;
  logic              last_slot_s;
  logic              last_pack_s;
  logic [WORD_W-1:0] word_s;
  logic [ADDR_W-1:0] addr_s;

  assign resync_s    = sw_sync_q ^ old_sw_q;
  assign mark_s      = (slot_q == SLOT_W'(0)) && (pack_q == PACK_W'(0));
  assign store_s     = (32'(slot_q) < WORDS_PER_PACK);
  assign last_slot_s = (slot_q == SLOT_W'(SLOTS_PER_PACK - 1));
  assign last_pack_s = (pack_q == PACK_W'(PACKS - 1));
  // Shift rather than concatenate a zero field so PAD_LSB = 0 stays legal.
  assign word_s      = WORD_W'({mark_s, bus.iData}) << PAD_LSB;
  // Arithmetic modulo 2**ADDR_W gives the required truncation directly.
  assign addr_s      = ADDR_W'(slot_q) * ADDR_W'(WORD_STRIDE)
                     + ADDR_W'(pack_q) * ADDR_W'(PACK_STRIDE);

  assign bus.orbWord   = word_q;
  assign bus.WE        = we_q;
  assign bus.WrAddr    = addr_q;
  assign bus.packDone  = pack_done_q;
  assign bus.frameDone = frame_done_q;
  assign bus.test      = test_q;

  // Two-flop synchronisers for strob and SW, plus the previous synced SW level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      str_meta_q <= 1'b0;
      str_sync_q <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_sync_q  <= 1'b0;
      old_sw_q   <= 1'b0;
    end else begin
      str_meta_q <= bus.strob;
      str_sync_q <= str_meta_q;
      sw_meta_q  <= bus.SW;
      sw_sync_q  <= sw_meta_q;
      old_sw_q   <= sw_sync_q;
    end
  end

  // Accept/wait FSM with slot/packet counters and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= SLOT_W'(0);
      pack_q       <= PACK_W'(0);
      word_q       <= WORD_W'(0);
      we_q         <= 1'b0;
      addr_q       <= ADDR_W'(0);
      pack_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      test_q       <= 1'b0;
    end else begin
      pack_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      test_q       <= 1'b0;
      if (resync_s) begin
        // Resync wins over an accept; a strobe already high is swallowed by
        // going straight to WAIT.
        slot_q  <= SLOT_W'(0);
        pack_q  <= PACK_W'(0);
        we_q    <= 1'b0;
        test_q  <= 1'b1;
        state_q <= str_sync_q ? ST_WAIT : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (str_sync_q) begin
              state_q <= ST_WAIT;
              // Gap slots leave WE, orbWord and WrAddr untouched.
              if (store_s) begin
                we_q   <= 1'b1;
                word_q <= word_s;
                addr_q <= addr_s;
              end else begin
                we_q <= we_q;
              end
              if (last_slot_s) begin
                slot_q      <= SLOT_W'(0);
                pack_done_q <= 1'b1;
                if (last_pack_s) begin
                  pack_q       <= PACK_W'(0);
                  frame_done_q <= 1'b1;
                end else begin
                  pack_q <= pack_q + PACK_W'(1);
                end
              end else begin
                slot_q <= slot_q + SLOT_W'(1);
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (!str_sync_q) begin
              we_q    <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
          default: begin
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orb_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_orb_frame_packer
// Two packers share clk/rst: dut_a with the default 16-of-20 / 64-packet
// configuration, dut_b with DATA_W=10, PAD_LSB=1, 4-of-4 slots, 2 packets.
// Stimulus pushes expected events (write, packet done, resync) from a
// slot/packet reference model into per-DUT queues; a negedge monitor pops
// and compares them as the outputs appear.
// -----------------------------------------------------------------------------
module tb_orb_frame_packer;

  localparam int A_DW = 8, A_PAD = 3, A_WORDS = 16, A_SLOTS = 20, A_PACKS = 64;
  localparam int B_DW = 10, B_PAD = 1, B_WORDS = 4, B_SLOTS = 4, B_PACKS = 2;
  localparam int WSTRIDE = 2, PSTRIDE = 32;

  localparam int EV_WRITE = 0, EV_PACK = 1, EV_TEST = 2;

  typedef struct {
    int         kind;
    logic [11:0] word;
    logic [10:0] addr;
    bit          frame;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  orb_frame_packer_if #(.DATA_W(8),  .WORD_W(12), .ADDR_W(11)) bus_a ();
  orb_frame_packer_if #(.DATA_W(10), .WORD_W(12), .ADDR_W(11)) bus_b ();

  orb_frame_packer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  orb_frame_packer #(
    .DATA_W(10), .PAD_LSB(1), .WORD_W(12), .WORDS_PER_PACK(4),
    .SLOTS_PER_PACK(4), .PACKS(2), .WORD_STRIDE(2), .PACK_STRIDE(32), .ADDR_W(11)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  ev_t         qa[$];
  ev_t         qb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_slot[2];
  int          m_pack[2];
  bit          prev_we[2];
  logic [11:0] cur_word[2];
  logic [10:0] cur_addr[2];
  int          frames_seen[2];
  int          frames_exp[2];

  task automatic push_ev(input int w, input ev_t e);
    if (w == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic pop_ev(input int w, output bit ok, output ev_t e);
    e  = '{0, 12'h000, 11'h000, 1'b0};
    ok = 1'b0;
    if (w == 0) begin
      if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
    end else begin
      if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
    end
  endtask

  // Reference model: one strobe consumes one slot of the current packet.
  task automatic model_accept(input int w, input logic [9:0] d);
    int  dw, pad, words, slots, packs, mark, val;
    ev_t e;
    dw    = (w == 0) ? A_DW    : B_DW;
    pad   = (w == 0) ? A_PAD   : B_PAD;
    words = (w == 0) ? A_WORDS : B_WORDS;
    slots = (w == 0) ? A_SLOTS : B_SLOTS;
    packs = (w == 0) ? A_PACKS : B_PACKS;
    if (m_slot[w] < words) begin
      mark   = (m_slot[w] == 0 && m_pack[w] == 0) ? 1 : 0;
      val    = ((mark << dw) + (int'(d) & ((1 << dw) - 1))) << pad;
      e.kind = EV_WRITE;
      e.word = 12'(val);
      e.addr = 11'((m_slot[w] * WSTRIDE + m_pack[w] * PSTRIDE) % 2048);
      e.frame = 1'b0;
      push_ev(w, e);
    end
    m_slot[w] = m_slot[w] + 1;
    if (m_slot[w] == slots) begin
      m_slot[w] = 0;
      e.kind  = EV_PACK;
      e.word  = 12'h000;
      e.addr  = 11'h000;
      e.frame = (m_pack[w] == packs - 1);
      if (e.frame) frames_exp[w] = frames_exp[w] + 1;
      push_ev(w, e);
      m_pack[w] = (m_pack[w] + 1) % packs;
    end
  endtask

  task automatic model_resync(input int w);
    ev_t e;
    m_slot[w] = 0;
    m_pack[w] = 0;
    e = '{EV_TEST, 12'h000, 11'h000, 1'b0};
    push_ev(w, e);
  endtask

  task automatic check_out(input int w, input logic we, input logic [11:0] word,
                           input logic [10:0] addr, input logic pd, input logic fd,
                           input logic tst);
    ev_t e;
    bit  ok;
    if (we && !prev_we[w]) begin
      pop_ev(w, ok, e);
      n_tests++;
      if (!ok || e.kind != EV_WRITE) begin
        n_fail++;
        $display("FAIL write_unexpected dut%0d: got WE=1 orbWord=%h WrAddr=%0d, required event kind %0d (queued=%0d)",
                 w, word, addr, e.kind, ok);
      end else begin
        if (word !== e.word || addr !== e.addr) begin
          n_fail++;
          $display("FAIL write dut%0d: got orbWord=%h WrAddr=%0d, required orbWord=%h WrAddr=%0d",
                   w, word, addr, e.word, e.addr);
        end
        cur_word[w] = e.word;
        cur_addr[w] = e.addr;
      end
    end else if (we) begin
      n_tests++;
      if (word !== cur_word[w] || addr !== cur_addr[w]) begin
        n_fail++;
        $display("FAIL write_hold dut%0d: got orbWord=%h WrAddr=%0d, required orbWord=%h WrAddr=%0d",
                 w, word, addr, cur_word[w], cur_addr[w]);
      end
    end
    prev_we[w] = we;

    if (pd) begin
      pop_ev(w, ok, e);
      n_tests++;
      if (fd) frames_seen[w]++;
      if (!ok || e.kind != EV_PACK || fd !== e.frame) begin
        n_fail++;
        $display("FAIL packdone dut%0d: got packDone=1 frameDone=%0b, required kind %0d frameDone=%0b (queued=%0d)",
                 w, fd, e.kind, e.frame, ok);
      end
    end else if (fd) begin
      n_tests++;
      n_fail++;
      $display("FAIL framedone_alone dut%0d: got frameDone=1 packDone=0, required both or neither", w);
    end

    if (tst) begin
      pop_ev(w, ok, e);
      n_tests++;
      if (!ok || e.kind != EV_TEST) begin
        n_fail++;
        $display("FAIL test_pulse dut%0d: got test=1, required event kind %0d (queued=%0d)", w, e.kind, ok);
      end
    end
  endtask

  // Monitor: both DUTs sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    check_out(0, bus_a.WE, bus_a.orbWord, bus_a.WrAddr, bus_a.packDone, bus_a.frameDone, bus_a.test);
    check_out(1, bus_b.WE, bus_b.orbWord, bus_b.WrAddr, bus_b.packDone, bus_b.frameDone, bus_b.test);
  end

  task automatic check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_a_orbWord"},   int'(bus_a.orbWord),   0);
    check_val({tag, "_a_WE"},        int'(bus_a.WE),        0);
    check_val({tag, "_a_WrAddr"},    int'(bus_a.WrAddr),    0);
    check_val({tag, "_a_packDone"},  int'(bus_a.packDone),  0);
    check_val({tag, "_a_frameDone"}, int'(bus_a.frameDone), 0);
    check_val({tag, "_a_test"},      int'(bus_a.test),      0);
  endtask

  // One strobe of random width; sw_flip toggles SW on the same edge as strob rises.
  task automatic strobe(input int w, input logic [9:0] d, input bit sw_flip);
    @(negedge clk);
    if (w == 0) begin
      bus_a.iData = d[7:0];
      bus_a.strob = 1'b1;
      if (sw_flip) bus_a.SW = ~bus_a.SW;
    end else begin
      bus_b.iData = d;
      bus_b.strob = 1'b1;
      if (sw_flip) bus_b.SW = ~bus_b.SW;
    end
    if (sw_flip) model_resync(w);
    else         model_accept(w, d);
    repeat ($urandom_range(6, 3)) @(negedge clk);
    if (w == 0) bus_a.strob = 1'b0;
    else        bus_b.strob = 1'b0;
    repeat ($urandom_range(6, 3)) @(negedge clk);
  endtask

  task automatic sw_toggle_idle(input int w);
    @(negedge clk);
    if (w == 0) bus_a.SW = ~bus_a.SW;
    else        bus_b.SW = ~bus_b.SW;
    model_resync(w);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_slot[i] = 0; m_pack[i] = 0; prev_we[i] = 1'b0;
      cur_word[i] = 12'h000; cur_addr[i] = 11'h000;
      frames_seen[i] = 0; frames_exp[i] = 0;
    end
    bus_a.iData = 8'h00;  bus_a.strob = 1'b0; bus_a.SW = 1'b0;
    bus_b.iData = 10'h000; bus_b.strob = 1'b0; bus_b.SW = 1'b0;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // First packet with a known ramp, then the rest of the frame random.
    for (int i = 0; i < 16; i++) strobe(0, 10'(i + 1), 1'b0);
    for (int i = 16; i < 1280; i++) strobe(0, 10'($urandom_range(255, 0)), 1'b0);
    // Frame wrapped: this one lands at address 0 with the mark bit.
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);

    // Resync while idle, partway through a packet.
    for (int i = 0; i < 4; i++) strobe(0, 10'($urandom_range(255, 0)), 1'b0);
    sw_toggle_idle(0);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);

    // Resync coinciding with a strobe: that strobe must not write.
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);
    strobe(0, 10'($urandom_range(255, 0)), 1'b1);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);

    // Reset asserted while WE is high.
    @(negedge clk);
    bus_a.iData = 8'($urandom_range(255, 0));
    bus_a.strob = 1'b1;
    model_accept(0, {2'b00, bus_a.iData});
    for (int i = 0; i < 10 && !bus_a.WE; i++) @(negedge clk);
    check_val("we_before_reset", int'(bus_a.WE), 1);
    #2 rst = 1'b0;
    #1 check_zero_outputs("midwrite");
    bus_a.strob = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin m_slot[i] = 0; m_pack[i] = 0; end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);

    // SW held high through reset release gives exactly one resync.
    @(negedge clk);
    rst = 1'b0;
    bus_a.SW = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin m_slot[i] = 0; m_pack[i] = 0; end
    model_resync(0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    strobe(0, 10'($urandom_range(255, 0)), 1'b0);

    // Reparameterised packer: every slot stored, 2-packet frames.
    strobe(1, 10'h3FF, 1'b0);
    for (int i = 1; i < 16; i++) strobe(1, 10'($urandom_range(1023, 0)), 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_val("queue_a_empty", qa.size(), 0);
    check_val("queue_b_empty", qb.size(), 0);
    check_val("frames_a", frames_seen[0], frames_exp[0]);
    check_val("frames_b", frames_seen[1], frames_exp[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
